n64_vinfo_detect: RTL and testbench
===================================

# n64_vinfo_detect

Measures the N64 video stream in the N64 pixel-clock domain and derives the video-mode flags `N64_palmode` and `N64_interlaced` consumed by clock/reset housekeeping (HDMI clock selection in low-latency mode) and by the scaler. It counts horizontal-sync events per field and the horizontal phase of each vertical-sync event. It then applies hysteresis so that a single corrupted field cannot flip the HDMI clock source.

## Interface
- `PAL_LINE_THRESH`, 290: a field with lines ≥ this value votes PAL.
- `PHASE_TOL`, 8: maximum |vphase difference| between consecutive fields that still counts as "same phase".
- `HYST`, 2: number of consecutive agreeing votes required to change a flag (2..7).

- `N64_CLK_i`  in  1  N64 pixel clock.
- `nRST_i`  in  1  reset, asynchronous, active-low.
- `dvalid_i`  in  1  sync/data sample strobe; all sync inputs are evaluated only when high.
- `nVSYNC_i`  in  1  vertical sync, active-low.
- `nHSYNC_i`  in  1  horizontal sync, active-low.
- `palmode_o`  out  1  1 = PAL (≥ `PAL_LINE_THRESH` lines/field).
- `interlaced_o`  out  1  1 = interlaced (vsync phase alternates between fields).
- `field_o`  out  1  current field ID when interlaced, else 0.
- `lines_per_field_o`  out  10  line count of the last completed field.
- `vinfo_valid_o`  out  1  flags are based on measured data.

## Operation
- Edge detection:
  - `nHSYNC_i` and `nVSYNC_i` are registered on `dvalid_i`.
  - A falling edge (`hs_fe`/`vs_fe`) is a 1→0 transition between consecutive `dvalid_i` samples.
- `line_cnt` (10 b):
  - +1 on `hs_fe`, saturating at 1023.
- `hphase` (12 b):
  - +1 on each `dvalid_i`, saturating at 4095; cleared to 0 on `hs_fe`.
  - `vphase` is `hphase` at `vs_fe`, or 0 if `hs_fe` occurs in the same sample.
- Field end (`vs_fe`):
  - Captured line count = `line_cnt + hs_fe`.
  - `line_cnt` is then set to 0.
- State machine:
  - `WAIT_VS`: reset state. The first `vs_fe` clears the counters and moves to `MEAS`. Nothing is captured.
  - `MEAS`: the next `vs_fe` updates `lines_per_field_o`, stores `vphase_prev`, records the first PAL vote, then moves to `RUN`.
  - `RUN`: each `vs_fe` does all of the following:
    - updates `lines_per_field_o`;
    - casts a PAL vote (`lines ≥ PAL_LINE_THRESH`);
    - casts an interlace vote (`|vphase − vphase_prev| > PHASE_TOL`);
    - stores `vphase_prev`.
- Hysteresis, per flag:
  - Each flag has a 3-bit agree counter.
  - A vote equal to the current flag clears the counter.
  - A differing vote increments it.
  - When the counter reaches `HYST`, the flag toggles and the counter clears.
  - There is one exception: the first PAL decision after reset loads directly once `HYST` identical votes have accumulated since entering `MEAS`.
- `vinfo_valid_o`:
  - Set together with that first PAL decision.
  - Remains 1 until reset.
- `field_o`:
  - When `interlaced_o` = 1 after the update, `field_o` = (`vphase > vphase_prev`).
  - Otherwise 0.
- Reset:
  - All outputs are 0 during reset.
  - All counters and votes are 0 and the FSM is in `WAIT_VS`.
  - Reset mid-field discards the partial measurement.

## Timing
- All outputs are registered. They update one `N64_CLK_i` cycle after the `dvalid_i` cycle carrying `vs_fe`.
- Outputs are constant between field ends.
- Reaction times with `HYST` = 2, counted from reset:
  - `vinfo_valid_o` and `palmode_o` are valid at the 3rd `vs_fe`.
  - `interlaced_o` can first assert at the 4th `vs_fe`.
- A mode change needs `HYST` consecutive agreeing fields. A single deviating field leaves the flags unchanged and resets its agree counter on the next agreeing field.
- When `dvalid_i` is low, all state holds, including the edge-detect registers.
- Simultaneous `hs_fe`/`vs_fe`: the line is counted in the ending field and `vphase` = 0.

## Structure
- The shared header `lib/videotimings.vh` holds:
  - `PAL_LINE_THRESH` and `PHASE_TOL` default constants;
  - counter widths (10 / 12);
  - FSM state encodings `WAIT_VS` / `MEAS` / `RUN`.
- Sub-module `vinfo_hyst_filter` (vote in, strobe, `HYST` parameter, flag out, first-load flag) is instantiated twice: once for PAL, once for interlace.

## Test plan
- **NTSC progressive:** 263 `hs_fe` per field, `vs_fe` at `vphase` 0, 5 fields -> after the 3rd `vs_fe`: `palmode_o`=0, `vinfo_valid_o`=1, `lines_per_field_o`=263; `interlaced_o`=0, `field_o`=0 throughout.
- **PAL interlaced:** 312/313 lines alternating, `vphase` alternating 0/386 -> `palmode_o`=1 at the 3rd `vs_fe`; `interlaced_o`=1 at the 4th `vs_fe`; `field_o` toggles each field thereafter.
- **Glitch immunity:** stable NTSC, one field of 312 lines, then 263 again -> `palmode_o` stays 0 and `lines_per_field_o` shows 312 for exactly one field; PAL with `vphase` jitter of ±8 -> `interlaced_o` stays 0.
- **Reset mid-field:** `nRST_i` low for 3 cycles at line 100 -> all outputs 0 immediately (async); the first post-reset `vs_fe` produces no capture; valid again at the 3rd `vs_fe`.
- **Simultaneous edges:** `hs_fe` and `vs_fe` in the same `dvalid_i` sample after 262 prior `hs_fe` -> `lines_per_field_o`=263, `vphase`=0.
- **Saturation and strobe gating:** 1100 `hs_fe` without `vs_fe`, then `vs_fe` -> `lines_per_field_o`=1023 and a PAL vote of 1; `dvalid_i` held low for 500 cycles mid-line -> counters unchanged.

Source files
------------

// File: rtl/n64_vinfo_detect_pkg.sv
// Shared constants, state encoding and helpers for the N64 video-info detector.
package n64_vinfo_detect_pkg;

    localparam int LINE_W              = 10;
    localparam int HPHASE_W            = 12;
    localparam int AGREE_W             = 3;

    localparam int PAL_LINE_THRESH_DEF = 290;
    localparam int PHASE_TOL_DEF       = 8;
    localparam int HYST_DEF            = 2;

    localparam logic [LINE_W-1:0]   LINE_MAX   = '1;
    localparam logic [HPHASE_W-1:0] HPHASE_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        MEAS    = 2'd1,
        RUN     = 2'd2
    } vinfo_state_e;

    // Unsigned distance between two horizontal phases.
    function automatic logic [HPHASE_W-1:0] phase_dist(input logic [HPHASE_W-1:0] a,
                                                       input logic [HPHASE_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/n64_vinfo_detect_if.sv
// Sync-sample inputs and mode-flag outputs of the video-info detector.
interface n64_vinfo_detect_if;
    import n64_vinfo_detect_pkg::*;

    logic              dvalid_i;
    logic              nVSYNC_i;
    logic              nHSYNC_i;
    logic              palmode_o;
    logic              interlaced_o;
    logic              field_o;
    logic [LINE_W-1:0] lines_per_field_o;
    logic              vinfo_valid_o;

    // Video source side: drives sync samples, observes the flags.
    modport master (
        output dvalid_i, nVSYNC_i, nHSYNC_i,
        input  palmode_o, interlaced_o, field_o, lines_per_field_o, vinfo_valid_o
    );

    // Detector side.
    modport slave (
        input  dvalid_i, nVSYNC_i, nHSYNC_i,
        output palmode_o, interlaced_o, field_o, lines_per_field_o, vinfo_valid_o
    );

endinterface

// File: rtl/vinfo_hyst_filter.sv
// Per-flag hysteresis: a flag only changes after HYST consecutive votes
// disagreeing with it. With FIRST_LOAD set, the flag has no value until HYST
// identical votes have been seen, and loaded_o marks that first decision.
module vinfo_hyst_filter
    import n64_vinfo_detect_pkg::*;
#(
    parameter int HYST       = HYST_DEF,
    parameter bit FIRST_LOAD = 1'b1
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic stb_i,
    input  logic vote_i,
    output logic flag_o,
    output logic loaded_o
);

    localparam logic [AGREE_W-1:0] HYST_C = AGREE_W'(HYST);

    logic               flag_q,   flag_d;
    logic               cand_q,   cand_d;
    logic               loaded_q, loaded_d;
    logic [AGREE_W-1:0] cnt_q,    cnt_d;
    logic [AGREE_W-1:0] cnt_inc;

    // Next-state: identical-vote run before the first decision, disagree run afterwards.
    always_comb begin
        flag_d   = flag_q;
        cand_d   = cand_q;
        loaded_d = loaded_q;
        cnt_d    = cnt_q;
        cnt_inc  = cnt_q + 1'b1;
        if (stb_i) begin
            if (!loaded_q) begin
                cnt_d  = (cnt_q != '0 && vote_i == cand_q) ? cnt_inc : AGREE_W'(1);
                cand_d = vote_i;
                if (cnt_d >= HYST_C) begin
                    flag_d   = vote_i;
                    loaded_d = 1'b1;
                    cnt_d    = '0;
                end
            end else if (vote_i == flag_q) begin
                cnt_d = '0;
            end else if (cnt_inc >= HYST_C) begin
                flag_d = ~flag_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    // Filter state registers; a filter without first-load starts decided at 0.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            flag_q   <= 1'b0;
            cand_q   <= 1'b0;
            loaded_q <= !FIRST_LOAD;
            cnt_q    <= '0;
        end else begin
            flag_q   <= flag_d;
            cand_q   <= cand_d;
            loaded_q <= loaded_d;
            cnt_q    <= cnt_d;
        end
    end

    assign flag_o   = flag_q;
    assign loaded_o = loaded_q;

endmodule

// File: rtl/n64_vinfo_detect.sv
// Measures N64 field length and vsync phase, and derives PAL / interlace flags
// through hysteresis so a single corrupted field cannot flip the video mode.
//
// state   | meaning
// --------+-----------------------------------------------------------
// WAIT_VS | after reset; first vsync only aligns the line counter
// MEAS    | first full field in progress; its end gives the first PAL vote
// RUN     | steady state; every field end votes PAL and interlace
module n64_vinfo_detect
    import n64_vinfo_detect_pkg::*;
#(
    parameter int PAL_LINE_THRESH = PAL_LINE_THRESH_DEF,
    parameter int PHASE_TOL       = PHASE_TOL_DEF,
    parameter int HYST            = HYST_DEF
) (
    input  logic              N64_CLK_i,
    input  logic              nRST_i,
    n64_vinfo_detect_if.slave vif
);

    localparam logic [LINE_W-1:0]   PAL_TH_C = LINE_W'(PAL_LINE_THRESH);
    localparam logic [HPHASE_W-1:0] TOL_C    = HPHASE_W'(PHASE_TOL);

    logic                hs_q, vs_q;
    logic                hs_fe, vs_fe;
    logic [LINE_W-1:0]   line_cnt_q, line_cap;
    logic [HPHASE_W-1:0] hphase_q, vphase, vphase_prev_q;
    logic [LINE_W-1:0]   lines_q;
    logic                field_raw_q;
    vinfo_state_e        state_q;
    logic                pal_vote, il_vote, pal_stb, il_stb;
    logic                pal_flag, il_flag, pal_loaded, il_loaded;

    assign hs_fe    = vif.dvalid_i & hs_q & ~vif.nHSYNC_i;
    assign vs_fe    = vif.dvalid_i & vs_q & ~vif.nVSYNC_i;
    // A line starting in the vsync sample still belongs to the ending field.
    assign line_cap = (hs_fe && line_cnt_q != LINE_MAX) ? line_cnt_q + 1'b1 : line_cnt_q;
    assign vphase   = hs_fe ? '0 : hphase_q;

    assign pal_vote = (line_cap >= PAL_TH_C);
    assign il_vote  = (phase_dist(vphase, vphase_prev_q) > TOL_C);
    assign pal_stb  = vs_fe & (state_q != WAIT_VS);
    assign il_stb   = vs_fe & (state_q == RUN);

    // Edge detect, line/phase counters, field-end capture and sequencing state.
    always_ff @(posedge N64_CLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            line_cnt_q    <= '0;
            hphase_q      <= '0;
            vphase_prev_q <= '0;
            lines_q       <= '0;
            field_raw_q   <= 1'b0;
            state_q       <= WAIT_VS;
        end else if (vif.dvalid_i) begin
            hs_q <= vif.nHSYNC_i;
            vs_q <= vif.nVSYNC_i;
            if (hs_fe) begin
                hphase_q <= '0;
            end else if (hphase_q != HPHASE_MAX) begin
                hphase_q <= hphase_q + 1'b1;
            end
            line_cnt_q <= vs_fe ? '0 : line_cap;
            if (vs_fe) begin
                case (state_q)
                    WAIT_VS: state_q <= MEAS;
                    MEAS: begin
                        lines_q       <= line_cap;
                        vphase_prev_q <= vphase;
                        state_q       <= RUN;
                    end
                    RUN: begin
                        lines_q       <= line_cap;
                        vphase_prev_q <= vphase;
                        field_raw_q   <= (vphase > vphase_prev_q);
                    end
                    default: state_q <= WAIT_VS;
                endcase
            end
        end
    end

    vinfo_hyst_filter #(.HYST(HYST), .FIRST_LOAD(1'b1)) u_pal_filt (
        .clk_i    (N64_CLK_i),
        .nrst_i   (nRST_i),
        .stb_i    (pal_stb),
        .vote_i   (pal_vote),
        .flag_o   (pal_flag),
        .loaded_o (pal_loaded)
    );

    // Interlace starts decided as progressive, so it never gates validity.
    vinfo_hyst_filter #(.HYST(HYST), .FIRST_LOAD(1'b0)) u_il_filt (
        .clk_i    (N64_CLK_i),
        .nrst_i   (nRST_i),
        .stb_i    (il_stb),
        .vote_i   (il_vote),
        .flag_o   (il_flag),
        .loaded_o (il_loaded)
    );

    assign vif.palmode_o         = pal_flag;
    assign vif.interlaced_o      = il_flag;
    assign vif.field_o           = il_flag & field_raw_q;
    assign vif.lines_per_field_o = lines_q;
    assign vif.vinfo_valid_o     = pal_loaded & il_loaded;

endmodule

// File: tb/tb_n64_vinfo_detect.sv
// Bench for n64_vinfo_detect: field-level behavioural model plus directed
// scenarios with literal expectations and a randomized field sequence.
module tb_n64_vinfo_detect;

    localparam int HYST   = 2;
    localparam int PAL_TH = 290;
    localparam int TOL    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    n64_vinfo_detect_if vif ();

    n64_vinfo_detect #(
        .PAL_LINE_THRESH(PAL_TH),
        .PHASE_TOL      (TOL),
        .HYST           (HYST)
    ) dut (
        .N64_CLK_i(clk),
        .nRST_i   (rst_n),
        .vif      (vif)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;
    bit gap_en = 1'b0;

    // model state
    int m_phs, m_pvs, m_lines, m_hph, m_nvs, m_vprev, m_pal_dis, m_il_dis;
    bit m_pal_loaded;
    int m_votes[$];
    int e_lines, e_pal, e_il, e_field, e_valid;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phs = 0; m_pvs = 0; m_lines = 0; m_hph = 0; m_nvs = 0; m_vprev = 0;
        m_pal_dis = 0; m_il_dis = 0; m_pal_loaded = 1'b0;
        m_votes.delete();
        e_lines = 0; e_pal = 0; e_il = 0; e_field = 0; e_valid = 0;
    endtask

    task automatic pal_vote(input int v);
        if (!m_pal_loaded) begin
            m_votes.push_back(v);
            if (m_votes.size() >= HYST) begin
                bit same;
                same = 1'b1;
                for (int i = m_votes.size() - HYST; i < m_votes.size(); i++)
                    if (m_votes[i] != v) same = 1'b0;
                if (same) begin
                    e_pal = v; e_valid = 1; m_pal_loaded = 1'b1; m_pal_dis = 0;
                end
            end
        end else if (v == e_pal) begin
            m_pal_dis = 0;
        end else begin
            m_pal_dis++;
            if (m_pal_dis >= HYST) begin e_pal = 1 - e_pal; m_pal_dis = 0; end
        end
    endtask

    task automatic il_vote(input int v);
        if (v == e_il) begin
            m_il_dis = 0;
        end else begin
            m_il_dis++;
            if (m_il_dis >= HYST) begin e_il = 1 - e_il; m_il_dis = 0; end
        end
    endtask

    // One accepted sample: what the outputs must become after this clock.
    task automatic model_step(input bit dv, input bit vs, input bit hs);
        bit hfe, vfe;
        int cap, vp, d;
        if (dv) begin
            hfe = (m_phs == 1 && hs == 1'b0);
            vfe = (m_pvs == 1 && vs == 1'b0);
            m_phs = int'(hs);
            m_pvs = int'(vs);
            if (vfe) begin
                cap = m_lines + (hfe ? 1 : 0);
                if (cap > 1023) cap = 1023;
                vp = hfe ? 0 : m_hph;
                m_nvs++;
                if (m_nvs >= 2) begin
                    e_lines = cap;
                    pal_vote((cap >= PAL_TH) ? 1 : 0);
                end
                if (m_nvs >= 3) begin
                    d = (vp > m_vprev) ? vp - m_vprev : m_vprev - vp;
                    il_vote((d > TOL) ? 1 : 0);
                    e_field = (e_il == 1 && vp > m_vprev) ? 1 : 0;
                end
                if (m_nvs >= 2) m_vprev = vp;
            end
            m_hph = hfe ? 0 : ((m_hph < 4095) ? m_hph + 1 : 4095);
            if (vfe) m_lines = 0;
            else if (hfe && m_lines < 1023) m_lines++;
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("lines_per_field", int'(vif.lines_per_field_o), e_lines);
            chk("palmode",         int'(vif.palmode_o),         e_pal);
            chk("interlaced",      int'(vif.interlaced_o),      e_il);
            chk("field",           int'(vif.field_o),           e_field);
            chk("vinfo_valid",     int'(vif.vinfo_valid_o),     e_valid);
        end
    end

    task automatic cyc(input bit dv, input bit vs, input bit hs);
        @(negedge clk);
        vif.dvalid_i = dv;
        vif.nVSYNC_i = vs;
        vif.nHSYNC_i = hs;
        @(posedge clk);
        #1;
        if (rst_n) model_step(dv, vs, hs);
    endtask

    task automatic sample(input bit vs, input bit hs);
        if (gap_en && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cyc(1'b1, vs, hs);
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            sample(1'b1, 1'b0);
            sample(1'b1, 1'b1);
        end
    endtask

    task automatic vs_end(input int tail);
        repeat (tail) sample(1'b1, 1'b1);
        repeat (3) sample(1'b0, 1'b1);
        sample(1'b1, 1'b1);
    endtask

    task automatic field(input int n, input int tail);
        lines(n);
        vs_end(tail);
    endtask

    // Last line's hsync edge lands in the same sample as the vsync edge.
    task automatic field_simul(input int n);
        lines(n - 1);
        sample(1'b0, 1'b0);
        repeat (2) sample(1'b0, 1'b1);
        sample(1'b1, 1'b1);
    endtask

    task automatic reset_pulse(input bit check_now);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        if (check_now) begin
            chk("async_rst_lines", int'(vif.lines_per_field_o), 0);
            chk("async_rst_pal",   int'(vif.palmode_o),         0);
            chk("async_rst_valid", int'(vif.vinfo_valid_o),     0);
            chk("async_rst_il",    int'(vif.interlaced_o),      0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vif.dvalid_i = 1'b0;
        vif.nVSYNC_i = 1'b1;
        vif.nHSYNC_i = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_lines", int'(vif.lines_per_field_o), 0);
        chk("reset_pal",   int'(vif.palmode_o),         0);
        chk("reset_valid", int'(vif.vinfo_valid_o),     0);
        chk("reset_il",    int'(vif.interlaced_o),      0);
        chk("reset_field", int'(vif.field_o),           0);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // NTSC progressive
        field(263, 0); field(263, 0);
        chk("ntsc_f2_valid", int'(vif.vinfo_valid_o), 0);
        field(263, 0);
        chk("ntsc_f3_valid", int'(vif.vinfo_valid_o), 1);
        chk("ntsc_f3_pal",   int'(vif.palmode_o), 0);
        chk("ntsc_f3_lines", int'(vif.lines_per_field_o), 263);
        chk("model_ntsc_lines", e_lines, 263);
        field(263, 0); field(263, 0);
        chk("ntsc_f5_il",    int'(vif.interlaced_o), 0);
        chk("ntsc_f5_field", int'(vif.field_o), 0);

        // PAL interlaced, vphase alternating 1/386
        reset_pulse(1'b0);
        for (int k = 1; k <= 6; k++) begin
            field((k % 2 == 1) ? 312 : 313, (k % 2 == 1) ? 0 : 385);
            if (k == 3) begin
                chk("pal_f3_pal",   int'(vif.palmode_o), 1);
                chk("pal_f3_valid", int'(vif.vinfo_valid_o), 1);
                chk("pal_f3_il",    int'(vif.interlaced_o), 0);
                chk("model_pal_f3", e_pal, 1);
            end
            if (k == 4) begin
                chk("pal_f4_il",    int'(vif.interlaced_o), 1);
                chk("pal_f4_field", int'(vif.field_o), 1);
                chk("model_il_f4",  e_il, 1);
            end
            if (k == 5) chk("pal_f5_field", int'(vif.field_o), 0);
            if (k == 6) chk("pal_f6_field", int'(vif.field_o), 1);
        end

        // Glitch immunity on stable NTSC
        reset_pulse(1'b0);
        gap_en = 1'b1;
        repeat (4) field(263, 3);
        field(312, 3);
        chk("glitch_lines", int'(vif.lines_per_field_o), 312);
        chk("glitch_pal",   int'(vif.palmode_o), 0);
        field(263, 3);
        chk("glitch_after_lines", int'(vif.lines_per_field_o), 263);
        field(312, 3);
        field(263, 3);
        chk("glitch2_pal", int'(vif.palmode_o), 0);

        // PAL with vphase differing by exactly the tolerance
        reset_pulse(1'b0);
        for (int k = 1; k <= 6; k++) field(312, (k % 2 == 1) ? 100 : 108);
        chk("jitter_il",  int'(vif.interlaced_o), 0);
        chk("jitter_pal", int'(vif.palmode_o), 1);

        // Reset mid-field at line 100
        gap_en = 1'b0;
        reset_pulse(1'b0);
        repeat (3) field(312, 0);
        lines(100);
        reset_pulse(1'b1);
        lines(212);
        vs_end(0);
        chk("rst_f1_lines", int'(vif.lines_per_field_o), 0);
        chk("rst_f1_valid", int'(vif.vinfo_valid_o), 0);
        field(312, 0);
        chk("rst_f2_valid", int'(vif.vinfo_valid_o), 0);
        field(312, 0);
        chk("rst_f3_valid", int'(vif.vinfo_valid_o), 1);
        chk("rst_f3_pal",   int'(vif.palmode_o), 1);

        // Simultaneous hsync/vsync edges alternating with vphase 9
        reset_pulse(1'b0);
        for (int k = 1; k <= 5; k++) begin
            if (k % 2 == 0) field_simul(263);
            else field(263, 8);
            if (k == 2) chk("simul_lines", int'(vif.lines_per_field_o), 263);
            if (k == 4) begin
                chk("simul_il",    int'(vif.interlaced_o), 1);
                chk("simul_field", int'(vif.field_o), 0);
            end
            if (k == 5) chk("simul_f5_field", int'(vif.field_o), 1);
        end

        // Saturation and dvalid gating
        reset_pulse(1'b0);
        field(10, 0);
        field(1100, 0);
        chk("sat_lines", int'(vif.lines_per_field_o), 1023);
        field(1100, 0);
        chk("sat_pal",   int'(vif.palmode_o), 1);
        chk("sat_valid", int'(vif.vinfo_valid_o), 1);
        lines(150);
        repeat (500) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        lines(150);
        vs_end(0);
        chk("gate_lines", int'(vif.lines_per_field_o), 300);

        // Randomized field sequence
        reset_pulse(1'b0);
        gap_en = 1'b1;
        for (int f = 0; f < 16; f++) begin
            int n, t, kind;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       n = 263;
                1:       n = 312;
                2:       n = 313;
                default: n = int'($urandom_range(250, 330));
            endcase
            t = ($urandom_range(0, 1) == 1) ? int'($urandom_range(380, 400)) : int'($urandom_range(0, 20));
            if ($urandom_range(0, 5) == 0) field_simul(n);
            else field(n, t);
        end

        repeat (4) @(posedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
